// File: rtl/store_buffer_pkg.sv
// Shared defaults and drain-FSM encoding for the store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

    localparam int SB_AW    = 16;
    localparam int SB_DW    = 16;
    localparam int SB_DEPTH = 4;

    // Drain FSM: IDLE waits for a buffered store, REQ holds the head write
    // until memory acknowledges it.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: youngest valid entry whose address matches ld_addr.
// Latency: combinational.
// Backpressure: none; pure lookup over the current buffer contents.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [AW-1:0]            ent_addr [DEPTH],
    input  logic [DW-1:0]            ent_data [DEPTH],
    input  logic [DEPTH-1:0]         valid,
    input  logic [$clog2(DEPTH)-1:0] head_idx,
    input  logic [AW-1:0]            ld_addr,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    localparam int IW = $clog2(DEPTH);

    // Walk from the head (oldest) toward the tail; a later match overrides an
    // earlier one, so the youngest matching store is the one reported.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[head_idx + IW'(i)] &&
                (ent_addr[head_idx + IW'(i)] == ld_addr)) begin
                hit  = 1'b1;
                data = ent_data[head_idx + IW'(i)];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores drained to data memory, with load forwarding.
// Latency: a store pushed into an empty, idle buffer raises dmem_req one edge later.
// Backpressure: sb_full stalls upstream; dmem_ack=0 holds the head request indefinitely.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,   // power of two, at least 2
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_w_en,
    input  logic [AW-1:0] mem_w_addr,
    input  logic [DW-1:0] mem_w_data,
    output logic          sb_full,
    output logic          sb_empty,
    output logic          sb_overflow,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          dmem_req,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;   // extra wrap bit separates full from empty

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_next;
    logic [DEPTH-1:0] valid;
    logic             push;
    logic             pop;
    sb_state_t        state;

    assign count      = wr_ptr - rd_ptr;
    assign sb_full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign sb_empty   = (wr_ptr == rd_ptr) && (state == ST_IDLE);

    // A store arriving while full is dropped even if the head pops this edge.
    assign push       = mem_w_en && !sb_full;
    assign pop        = (state == ST_REQ) && dmem_ack;
    assign count_next = count + PW'(push) - PW'(pop);

    assign dmem_req   = (state == ST_REQ);
    assign dmem_addr  = ent_addr[rd_ptr[IW-1:0]];
    assign dmem_wdata = ent_data[rd_ptr[IW-1:0]];

    // Occupancy mask: slot j is live when its distance from the head is below count.
    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            valid[j] = ({1'b0, IW'(j) - rd_ptr[IW-1:0]} < count);
        end
    end

    // Entry storage; written only on an accepted push, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr[IW-1:0]] <= mem_w_addr;
            ent_data[wr_ptr[IW-1:0]] <= mem_w_data;
        end
    end

    // Write and read pointers advance modulo 2*DEPTH; reset discards all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Drain FSM: request the head while entries exist; leave REQ only when the
    // acknowledged pop empties the buffer (counting a same-edge push).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (count != '0) state <= ST_REQ;
                ST_REQ:  if (pop && (count_next == '0)) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag: any store presented while full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_overflow <= 1'b0;
        end else if (mem_w_en && sb_full) begin
            sb_overflow <= 1'b1;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .head_idx (rd_ptr[IW-1:0]),
        .ld_addr  (ld_addr),
        .hit      (ld_hit),
        .data     (ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, full/overflow, forwarding, reset.
// Latency: n/a.
// Backpressure: dmem_ack driven per test to hold or release the drain.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        mem_w_en;
    logic [15:0] mem_w_addr;
    logic [15:0] mem_w_data;
    logic        sb_full;
    logic        sb_empty;
    logic        sb_overflow;
    logic [15:0] ld_addr;
    logic        ld_hit;
    logic [15:0] ld_data;
    logic        dmem_req;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] wq [$];
    int          sent;
    int          cyc;

    store_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_w_en    (mem_w_en),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .sb_full     (sb_full),
        .sb_empty    (sb_empty),
        .sb_overflow (sb_overflow),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_data     (ld_data),
        .dmem_req    (dmem_req),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every accepted memory write as {addr, data}.
    always @(posedge clk) begin
        if (reset && dmem_req && dmem_ack) wq.push_back({dmem_addr, dmem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        ld_addr    = '0;
        dmem_ack   = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        wq.delete();
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        mem_w_en   = 1'b1;
        mem_w_addr = a;
        mem_w_data = d;
        step();
        mem_w_en   = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!sb_empty && n < 60) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(sb_empty), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_empty",    32'(sb_empty),    32'd1);
        check("rst_full",     32'(sb_full),     32'd0);
        check("rst_req",      32'(dmem_req),    32'd0);
        check("rst_overflow", 32'(sb_overflow), 32'd0);
        check("rst_ld_hit",   32'(ld_hit),      32'd0);
        check("rst_ld_data",  32'(ld_data),     32'd0);

        // Single store, ack already high: req one edge after the push edge
        dmem_ack = 1'b1;
        store(16'h0040, 16'hBEEF);
        check("t1_req_after_push", 32'(dmem_req), 32'd0);
        check("t1_not_empty",      32'(sb_empty), 32'd0);
        step();
        check("t1_req",   32'(dmem_req),   32'd1);
        check("t1_addr",  32'(dmem_addr),  32'h0040);
        check("t1_wdata", 32'(dmem_wdata), 32'hBEEF);
        step();
        check("t1_req_done", 32'(dmem_req),  32'd0);
        check("t1_empty",    32'(sb_empty),  32'd1);
        check("t1_nwrites",  32'(wq.size()), 32'd1);
        check("t1_write0",   wq[0],          32'h0040BEEF);

        // Five back-to-back stores with ack held low: fifth dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_w_en   = 1'b1;
            mem_w_addr = 16'h0010 + 16'(i);
            mem_w_data = 16'hA010 + 16'(i);
            step();
            if (i == 3) begin
                check("t2_full_at4",   32'(sb_full),     32'd1);
                check("t2_ovf_at4",    32'(sb_overflow), 32'd0);
            end
        end
        mem_w_en = 1'b0;
        check("t2_full",     32'(sb_full),     32'd1);
        check("t2_overflow", 32'(sb_overflow), 32'd1);
        dmem_ack = 1'b1;
        wait_empty("t2");
        check("t2_nwrites",   32'(wq.size()),    32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_write%0d", i), wq[i], {16'h0010 + 16'(i), 16'hA010 + 16'(i)});
        check("t2_ovf_sticky", 32'(sb_overflow), 32'd1);

        // Forwarding: youngest match wins, miss reads zero, same-cycle store not seen
        do_reset();
        store(16'h0020, 16'h1111);
        store(16'h0020, 16'h2222);
        ld_addr = 16'h0020;
        #1;
        check("t3_hit",      32'(ld_hit),  32'd1);
        check("t3_data",     32'(ld_data), 32'h2222);
        ld_addr = 16'h0022;
        #1;
        check("t3_miss_hit",  32'(ld_hit),  32'd0);
        check("t3_miss_data", 32'(ld_data), 32'h0000);
        mem_w_en   = 1'b1;
        mem_w_addr = 16'h0030;
        mem_w_data = 16'h3333;
        ld_addr    = 16'h0030;
        #1;
        check("t3_same_cycle_hit", 32'(ld_hit), 32'd0);
        step();
        mem_w_en = 1'b0;
        check("t3_after_push_hit",  32'(ld_hit),   32'd1);
        check("t3_after_push_data", 32'(ld_data),  32'h3333);
        check("t3_in_req",          32'(dmem_req), 32'd1);

        // Ten stores, ack every other cycle, upstream honours sb_full
        do_reset();
        sent = 0;
        cyc  = 0;
        while ((sent < 10 || !sb_empty) && cyc < 300) begin
            dmem_ack = cyc[0];
            if (sent < 10 && !sb_full) begin
                mem_w_en   = 1'b1;
                mem_w_addr = 16'h0100 + 16'(sent);
                mem_w_data = 16'hC000 + 16'(sent);
                sent++;
            end else begin
                mem_w_en = 1'b0;
            end
            step();
            cyc++;
        end
        mem_w_en = 1'b0;
        dmem_ack = 1'b0;
        check("t4_drained",  32'(sb_empty),    32'd1);
        check("t4_overflow", 32'(sb_overflow), 32'd0);
        check("t4_nwrites",  32'(wq.size()),   32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t4_write%0d", i), wq[i], {16'h0100 + 16'(i), 16'hC000 + 16'(i)});

        // Full with pop and push on the same edge: store dropped, room appears after
        do_reset();
        for (int i = 0; i < 4; i++) store(16'h0200 + 16'(i), 16'hD000 + 16'(i));
        check("t5_full", 32'(sb_full), 32'd1);
        mem_w_en   = 1'b1;
        mem_w_addr = 16'h02FF;
        mem_w_data = 16'hDEAD;
        dmem_ack   = 1'b1;
        step();
        mem_w_en = 1'b0;
        dmem_ack = 1'b0;
        check("t5_overflow", 32'(sb_overflow), 32'd1);
        check("t5_not_full", 32'(sb_full),     32'd0);
        check("t5_one_pop",  32'(wq.size()),   32'd1);
        // push and pop together keep count at 3; one more push fills it
        mem_w_en   = 1'b1;
        mem_w_addr = 16'h0204;
        mem_w_data = 16'hD004;
        dmem_ack   = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("t5_pushpop_not_full", 32'(sb_full), 32'd0);
        store(16'h0205, 16'hD005);
        check("t5_refull", 32'(sb_full), 32'd1);
        dmem_ack = 1'b1;
        wait_empty("t5");
        check("t5_nwrites", 32'(wq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t5_write%0d", i), wq[i], {16'h0200 + 16'(i), 16'hD000 + 16'(i)});

        // Reset while requesting with three entries pending
        do_reset();
        for (int i = 0; i < 3; i++) store(16'h0300 + 16'(i), 16'hE000 + 16'(i));
        check("t6_req_before", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_req_dropped", 32'(dmem_req), 32'd0);
        check("t6_empty_rst",   32'(sb_empty), 32'd1);
        @(negedge clk);
        reset    = 1'b1;
        dmem_ack = 1'b1;
        repeat (10) step();
        check("t6_req_after",   32'(dmem_req),  32'd0);
        check("t6_empty_after", 32'(sb_empty),  32'd1);
        check("t6_no_writes",   32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
